alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial command front end for the datapath ALU. It deserializes a command frame (opcode plus two 16-bit operands) from a 1-bit input stream, presents it to the combinational ALU for one cycle, captures the ALU result, and shifts that result out bit-serially under a valid/ready handshake. It is the initiator side of the ALU operand/result interface and sits between the serial link and the ALU.

## Interface
Parameters:
- DATA_W, 16, operand and result width; only 16 is supported.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ser_in  input  1  serial command bit, MSB first.
- ser_in_valid  input  1  ser_in carries a bit this cycle.
- ser_in_ready  output  1  block accepts a bit this cycle. A bit transfers when ser_in_valid && ser_in_ready.
- alu_op  output  alu_op_t  opcode driven to the ALU.
- alu_a  output  16  operand 1 driven to the ALU.
- alu_b  output  16  operand 2 driven to the ALU.
- alu_result  input  16  combinational ALU result.
- ser_out  output  1  result bit, MSB first.
- ser_out_valid  output  1  ser_out is valid.
- ser_out_ready  input  1  downstream accepts a bit. A bit transfers when ser_out_valid && ser_out_ready.
- busy  output  1  high whenever state != RECV, or the receive bit count is nonzero.
- frame_err  output  1  one-cycle pulse on a parity mismatch (parity build only).

## Operation
- Frame layout, MSB first: op[2:0], A[15:0], B[15:0], giving 35 bits; 36 bits when parity is enabled.
- Opcode encoding: ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, XOR=5, OR=6, AND=7. All 8 codes are legal.
- States:
  - RECV
    - ser_in_ready = 1.
    - Each transfer shifts into a 35-bit frame register and increments bit_cnt (6 bits).
    - On the final bit, go to EXEC and clear bit_cnt.
  - EXEC
    - alu_op/alu_a/alu_b are driven from the frame register.
    - Registered-output timing is the same as in every other state.
    - alu_result is latched into result_sr at the end of the cycle.
    - Next state is SEND.
  - SEND
    - ser_out_valid = 1 and ser_out = result_sr[15].
    - Each transfer shifts result_sr left and increments out_cnt (4 bits).
    - After the 16th transfer, go to RECV.
- alu_op/alu_a/alu_b:
  - Always reflect the frame register fields.
  - Change only during RECV shifting.
  - Are stable from EXEC until the next frame's first bit.
- ser_in_ready = 0 in EXEC and SEND; input bits offered there are not consumed.
- ser_out_valid = 0 outside SEND. ser_out = 0 when not valid.
- Stall: in SEND, if ser_out_ready = 0, then state, result_sr and ser_out hold.

## Timing
- Reset values:
  - state = RECV, all counters 0, frame register 0, result_sr 0.
  - alu_op = ADD, alu_a = 0, alu_b = 0.
  - ser_in_ready = 1, ser_out = 0, ser_out_valid = 0, busy = 0, frame_err = 0.
- Reset mid-frame or mid-send: state returns to RECV immediately and asynchronously; the partial frame or result is discarded.
- Latency:
  - The last input bit transfers in cycle N.
  - EXEC is cycle N+1.
  - The first ser_out_valid is cycle N+2.
  - With no backpressure, the last result bit is in cycle N+17.
  - ser_in_ready reasserts in cycle N+18.
- Throughput with no stalls: 35 + 1 + 16 = 52 cycles per frame.
- ser_in_valid is ignored while ser_in_ready = 0. No input buffering; the upstream must hold or retry.
- Outputs are registered, except ser_in_ready and ser_out_valid, which decode from state.

## Configuration
- ALU_SER_PARITY_EN defined:
  - Frame is 36 bits; the final bit is even parity over the preceding 35.
  - On mismatch:
    - frame_err pulses one cycle, in the cycle after the parity bit.
    - State stays RECV and the frame is dropped; no EXEC/SEND occurs.
    - alu_* outputs still show the bad frame's fields.
- ALU_SER_PARITY_EN undefined:
  - 35-bit frame.
  - frame_err is tied to 0.

## Structure
- Shared package: alu_op_t (3-bit enum above), the ctrl_state_t enum {RECV, EXEC, SEND}, and constants FRAME_BITS (35) and RESULT_BITS (16).
- One sub-module: ser_shift16, a 16-bit shift register.
  - Parallel load, MSB-first shift-out with enable, and hold.
  - Used for result_sr.
- The frame register stays inline.

## Test plan
- ADD: send op=0, A=0x1234, B=0x0001 with continuous valid -> alu_* stable from N+1; ser_out over N+2..N+17 = 0x1235 MSB first; ser_in_ready high at N+18.
- SRA: op=4, A=0x8000, B=0x0004 -> result 0xF800 serialized.
- SUB wrap: op=1, A=0x0000, B=0x0001 -> 0xFFFF.
- Backpressure: deassert ser_out_ready for 5 cycles after the 3rd result bit -> that bit holds with valid high; the total sequence is still the correct 16 bits. ser_in_valid pulses during SEND are not consumed.
- Reset mid-send (after the 7th result bit) -> next cycle: ser_out_valid = 0, state RECV, busy = 0. A following frame op=7, A=0xF0F0, B=0x0FF0 yields 0x00F0.
- Parity build: flip the parity bit on an ADD frame -> frame_err pulses once, no ser_out_valid; the next good frame processes normally.

Source files
------------

// File: rtl/alu_serial_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl_pkg
//
// Shared types and constants for the bit-serial ALU command front end.
//
//   alu_op_t      : 3-bit ALU opcode, all eight codes legal
//   ctrl_state_t  : controller states RECV / EXEC / SEND
//   FRAME_BITS    : payload bits in a command frame (op + A + B)
//   RESULT_BITS   : width of the serialized ALU result
//   WIRE_BITS     : bits actually carried on the serial link per frame
//                   (payload plus parity bit when ALU_SER_PARITY_EN is set)
//
// Configuration macro: ALU_SER_PARITY_EN (adds an even-parity trailer bit).
// ---------------------------------------------------------------------------
package alu_serial_ctrl_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        SLL = 3'd2,
        SRL = 3'd3,
        SRA = 3'd4,
        XOR = 3'd5,
        OR  = 3'd6,
        AND = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        EXEC = 2'd1,
        SEND = 2'd2
    } ctrl_state_t;

    localparam int FRAME_BITS  = 35;
    localparam int RESULT_BITS = 16;

`ifdef ALU_SER_PARITY_EN
    localparam int WIRE_BITS = FRAME_BITS + 1;
`else
    localparam int WIRE_BITS = FRAME_BITS;
`endif

    // Even parity: the trailer bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [FRAME_BITS-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_ser_shift16.sv
// ---------------------------------------------------------------------------
// ser_shift16
//
// 16-bit parallel-load, MSB-first shift-out register used to hold the ALU
// result while it is serialized.
//
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset, clears the register
//   load       : capture load_data this cycle (wins over shift)
//   load_data  : parallel data to capture
//   shift      : shift left by one, zero-filling the LSB
//   shift_out  : current MSB, i.e. the bit presented on the serial output
//
// With neither load nor shift asserted the register holds.
// ---------------------------------------------------------------------------
module ser_shift16
    import alu_serial_ctrl_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [RESULT_BITS-1:0] load_data,
    input  logic                   shift,
    output logic                   shift_out
);

    logic [RESULT_BITS-1:0] sr;

    // Load has priority so a fresh result is never lost to a stray shift.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= {sr[RESULT_BITS-2:0], 1'b0};
        end
    end

    assign shift_out = sr[RESULT_BITS-1];

endmodule

// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Bit-serial command front end for the datapath ALU. A frame
// {op[2:0], A[15:0], B[15:0]} arrives MSB first on ser_in, is presented to
// the combinational ALU for one EXEC cycle, and the captured result is sent
// MSB first on ser_out under a valid/ready handshake.
//
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   ser_in         : serial command bit
//   ser_in_valid   : ser_in carries a bit
//   ser_in_ready   : block accepts a bit (RECV only)
//   alu_op/a/b     : frame fields driven to the ALU
//   alu_result     : combinational ALU result
//   ser_out        : result bit, 0 when not valid
//   ser_out_valid  : ser_out carries a bit (SEND only)
//   ser_out_ready  : downstream accepts the bit
//   busy           : not idle in RECV with an empty frame
//   frame_err      : one-cycle pulse on a parity mismatch
//
// Configuration macro: ALU_SER_PARITY_EN. When defined the frame carries a
// 36th even-parity bit; a mismatch pulses frame_err and drops the frame.
// When undefined the frame is 35 bits and frame_err is tied low.
// ---------------------------------------------------------------------------
module alu_serial_ctrl
    import alu_serial_ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ser_in,
    input  logic              ser_in_valid,
    output logic              ser_in_ready,
    output alu_op_t           alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              ser_out,
    output logic              ser_out_valid,
    input  logic              ser_out_ready,
    output logic              busy,
    output logic              frame_err
);

    ctrl_state_t           state;
    ctrl_state_t           next_state;
    logic [FRAME_BITS-1:0] frame;
    logic [5:0]            bit_cnt;
    logic [3:0]            out_cnt;
    logic                  in_fire;
    logic                  out_fire;
    logic                  last_in_bit;
    logic                  frame_shift;
    logic                  parity_bad;
    logic                  result_msb;

    // Handshake completions decode straight from the state register so the
    // next-state logic has no combinational feedback through itself.
    assign in_fire     = ser_in_valid  && (state == RECV);
    assign out_fire    = ser_out_ready && (state == SEND);
    assign last_in_bit = (bit_cnt == 6'(WIRE_BITS - 1));

    // Only payload bits enter the frame register; a trailing parity bit is
    // checked but never stored, so the ALU fields stay aligned.
    assign frame_shift = in_fire && (bit_cnt < 6'(FRAME_BITS));

`ifdef ALU_SER_PARITY_EN
    assign parity_bad = in_fire && last_in_bit && (ser_in != even_parity(frame));
`else
    assign parity_bad = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RECV;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode. EXEC always lasts exactly one cycle;
    // a frame that fails its parity check never leaves RECV.
    always_comb begin
        next_state    = state;
        ser_in_ready  = 1'b0;
        ser_out_valid = 1'b0;
        unique case (state)
            RECV: begin
                ser_in_ready = 1'b1;
                if (in_fire && last_in_bit && !parity_bad) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = SEND;
            end
            SEND: begin
                ser_out_valid = 1'b1;
                if (out_fire && (out_cnt == 4'd15)) begin
                    next_state = RECV;
                end
            end
            default: begin
                next_state = RECV;
            end
        endcase
    end

    // Frame deserializer and receive bit counter. The counter wraps to zero
    // on the final link bit whether or not the frame is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame   <= '0;
            bit_cnt <= '0;
        end else if (in_fire) begin
            if (frame_shift) begin
                frame <= {frame[FRAME_BITS-2:0], ser_in};
            end
            if (last_in_bit) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

    // Result bit counter; sixteen transfers wrap it back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_cnt <= '0;
        end else if (out_fire) begin
            out_cnt <= out_cnt + 4'd1;
        end
    end

`ifdef ALU_SER_PARITY_EN
    // Error pulse lands in the cycle after the offending parity bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= parity_bad;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

    // ALU operands are plain views of the frame register, so they only move
    // while bits are being shifted in and hold through EXEC and SEND.
    assign alu_op = alu_op_t'(frame[FRAME_BITS-1 -: 3]);
    assign alu_a  = frame[2*RESULT_BITS-1 -: RESULT_BITS];
    assign alu_b  = frame[RESULT_BITS-1:0];

    // Result serializer: captured at the end of EXEC, shifted on each accepted
    // output bit, held while the downstream stalls.
    ser_shift16 u_result_sr (
        .clock     (clock),
        .reset     (reset),
        .load      (state == EXEC),
        .load_data (alu_result),
        .shift     (out_fire),
        .shift_out (result_msb)
    );

    assign ser_out = (state == SEND) ? result_msb : 1'b0;
    assign busy    = (state != RECV) || (bit_cnt != 6'd0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_ctrl
//
// Scoreboard bench for alu_serial_ctrl. A behavioural ALU answers the DUT's
// operand outputs; each issued frame pushes its expected result, and a
// negedge monitor reassembles ser_out words and pops/compares them.
// Honours ALU_SER_PARITY_EN to add the parity trailer and error tests.
// ---------------------------------------------------------------------------
module tb_alu_serial_ctrl;
    import alu_serial_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        ser_in;
    logic        ser_in_valid;
    logic        ser_in_ready;
    alu_op_t     alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        ser_out;
    logic        ser_out_valid;
    logic        ser_out_ready;
    logic        busy;
    logic        frame_err;

    int          compared;
    int          mismatched;
    logic [15:0] sb_q[$];
    int          mon_bits;
    logic [15:0] mon_word;
    logic        prev_stall;
    logic        prev_bit;
    int          err_pulses;

    alu_serial_ctrl #(.DATA_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .ser_in        (ser_in),
        .ser_in_valid  (ser_in_valid),
        .ser_in_ready  (ser_in_ready),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_result    (alu_result),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .ser_out_ready (ser_out_ready),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU: shift amounts use the low four bits of B.
    function automatic logic [15:0] aluRef(input logic [2:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << b[3:0];
            3'd3:    return a >> b[3:0];
            3'd4:    return 16'($signed(a) >>> b[3:0]);
            3'd5:    return a ^ b;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = aluRef(alu_op, alu_a, alu_b);

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reassemble output words, check stall hold, count error pulses.
    initial begin
        mon_bits   = 0;
        mon_word   = '0;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        err_pulses = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                mon_bits   = 0;
                mon_word   = '0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && ser_out_valid) begin
                    checkOutput("stall_hold", {31'd0, ser_out}, {31'd0, prev_bit});
                end
                if (ser_out_valid && ser_out_ready) begin
                    mon_word = {mon_word[14:0], ser_out};
                    mon_bits++;
                    if (mon_bits == 16) begin
                        if (sb_q.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("[TB] FAIL unexpected_result: got 0x%0h, expected none", mon_word);
                        end else begin
                            checkOutput("result", {16'd0, mon_word}, {16'd0, sb_q.pop_front()});
                        end
                        mon_bits = 0;
                    end
                end
                prev_stall = ser_out_valid && !ser_out_ready;
                prev_bit   = ser_out;
                if (frame_err) err_pulses++;
            end
        end
    end

    task automatic sendBit(input logic b);
        int to;
        ser_in       = b;
        ser_in_valid = 1'b1;
        to = 0;
        @(negedge clock);
        while (!ser_in_ready && to < 100) begin
            @(negedge clock);
            to++;
        end
        if (to >= 100) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        ser_in_valid = 1'b0;
    endtask

    // Issue one frame; the expected result is queued unless the frame is
    // deliberately corrupted (parity build only).
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] expv,
                                 input bit flip_par);
        logic [34:0] frame;
        if (!flip_par) sb_q.push_back(expv);
        frame = {op, a, b};
        for (int i = 34; i >= 0; i--) sendBit(frame[i]);
`ifdef ALU_SER_PARITY_EN
        sendBit((^frame) ^ flip_par);
`endif
        ser_in_valid = 1'b0;
    endtask

    // Run until the DUT is idle again, optionally with random backpressure
    // and junk input bits that must not be consumed.
    task automatic drainResult(input bit random_bp, input bit junk_in);
        int to;
        to = 0;
        while (busy && to < 400) begin
            ser_out_ready = random_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            ser_in_valid  = junk_in ? 1'($urandom_range(0, 1)) : 1'b0;
            ser_in        = 1'($urandom);
            @(posedge clock);
            #1;
            to++;
        end
        ser_in_valid  = 1'b0;
        ser_out_ready = 1'b1;
        if (to >= 400) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitOutBits(input int n);
        int to;
        to = 0;
        while (mon_bits < n && to < 200) begin
            ser_in_valid = 1'b1;
            ser_in       = 1'($urandom);
            @(posedge clock);
            #1;
            to++;
        end
        ser_in_valid = 1'b0;
        if (to >= 200) checkOutput("out_bits_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  rop;
        logic [15:0] ra;
        logic [15:0] rb;
        compared      = 0;
        mismatched    = 0;
        reset         = 1'b1;
        ser_in        = 1'b0;
        ser_in_valid  = 1'b0;
        ser_out_ready = 1'b1;

        #23;
        checkOutput("rst_in_ready",  {31'd0, ser_in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'd0, ser_out_valid}, 32'd0);
        checkOutput("rst_ser_out",   {31'd0, ser_out},       32'd0);
        checkOutput("rst_busy",      {31'd0, busy},          32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err},     32'd0);
        checkOutput("rst_alu_op",    {29'd0, alu_op},        32'd0);
        checkOutput("rst_alu_a",     {16'd0, alu_a},         32'd0);
        checkOutput("rst_alu_b",     {16'd0, alu_b},         32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // ADD with latency checks; we return from applyStimulus in cycle N+1.
        applyStimulus(3'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0);
        checkOutput("exec_out_valid", {31'd0, ser_out_valid}, 32'd0);
        checkOutput("exec_in_ready",  {31'd0, ser_in_ready},  32'd0);
        checkOutput("exec_busy",      {31'd0, busy},          32'd1);
        checkOutput("exec_alu_op",    {29'd0, alu_op},        32'd0);
        checkOutput("exec_alu_a",     {16'd0, alu_a},         32'h1234);
        checkOutput("exec_alu_b",     {16'd0, alu_b},         32'h0001);
        @(posedge clock);
        #1;
        checkOutput("first_out_valid", {31'd0, ser_out_valid}, 32'd1);
        repeat (15) begin
            @(posedge clock);
            #1;
        end
        checkOutput("last_out_valid", {31'd0, ser_out_valid}, 32'd1);
        @(posedge clock);
        #1;
        checkOutput("in_ready_back", {31'd0, ser_in_ready},  32'd1);
        checkOutput("out_valid_off", {31'd0, ser_out_valid}, 32'd0);
        checkOutput("alu_a_stable",  {16'd0, alu_a},         32'h1234);

        // SRA and SUB wrap.
        applyStimulus(3'd4, 16'h8000, 16'h0004, 16'hF800, 1'b0);
        drainResult(1'b0, 1'b0);
        applyStimulus(3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0);
        drainResult(1'b0, 1'b0);

        // Directed backpressure after the 3rd result bit with junk input.
        applyStimulus(3'd0, 16'h00FF, 16'h0F01, 16'h1000, 1'b0);
        waitOutBits(3);
        ser_out_ready = 1'b0;
        ser_in_valid  = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #1;
            checkOutput("stall_valid", {31'd0, ser_out_valid}, 32'd1);
        end
        ser_in_valid  = 1'b0;
        ser_out_ready = 1'b1;
        drainResult(1'b0, 1'b1);

        // Reset after the 7th result bit discards the result.
        applyStimulus(3'd5, 16'hA5A5, 16'h3C3C, 16'h9999, 1'b0);
        waitOutBits(7);
        reset = 1'b1;
        sb_q.delete();
        #1;
        checkOutput("mid_rst_out_valid", {31'd0, ser_out_valid}, 32'd0);
        checkOutput("mid_rst_busy",      {31'd0, busy},          32'd0);
        checkOutput("mid_rst_in_ready",  {31'd0, ser_in_ready},  32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("post_rst_out_valid", {31'd0, ser_out_valid}, 32'd0);
        applyStimulus(3'd7, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0);
        drainResult(1'b0, 1'b0);

`ifdef ALU_SER_PARITY_EN
        begin
            int err0;
            err0 = err_pulses;
            applyStimulus(3'd0, 16'h1234, 16'h0001, 16'h0000, 1'b1);
            repeat (20) begin
                @(posedge clock);
                #1;
                if (ser_out_valid) checkOutput("par_no_send", 32'd1, 32'd0);
            end
            checkOutput("par_err_pulses", err_pulses - err0, 32'd1);
            checkOutput("par_busy", {31'd0, busy}, 32'd0);
            checkOutput("par_alu_a", {16'd0, alu_a}, 32'h1234);
            applyStimulus(3'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0);
            drainResult(1'b0, 1'b0);
        end
`endif

        // Randomized frames with random backpressure and junk input.
        for (int n = 0; n < 24; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            applyStimulus(rop, ra, rb, aluRef(rop, ra, rb), 1'b0);
            drainResult(1'b1, 1'b1);
        end

        repeat (3) @(posedge clock);
        #1;
        checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
        checkOutput("monitor_idle", mon_bits, 32'd0);
`ifndef ALU_SER_PARITY_EN
        checkOutput("no_frame_err", err_pulses, 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
